// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit 5-stage core: register file geometry,
// the NOP encoding loaded by squashed stage registers, and pipeline modes.
package core_pkg;

    localparam int NREG = 8;
    localparam int AW   = 3;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        MODE_RUN    = 2'd0,
        MODE_STALL  = 2'd1,
        MODE_FLUSH  = 2'd2,
        MODE_FREEZE = 2'd3
    } pipe_mode_e;

    function automatic logic is_zero_reg(input logic [AW-1:0] addr);
        return addr == {AW{1'b0}};
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register count of in-flight writers; pend[r] is set while any writer to
// r has issued but not yet committed. Register 0 is never tracked.
module hazard_scoreboard
    import core_pkg::*;
#(
    parameter int NREG = core_pkg::NREG,
    parameter int AW   = core_pkg::AW,
    parameter int CNTW = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            upd_en,
    input  logic            inc_en,
    input  logic [AW-1:0]   inc_addr,
    input  logic            dec_en,
    input  logic [AW-1:0]   dec_addr,
    output logic [NREG-1:0] pend
);

    localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
    localparam logic [CNTW-1:0] CNT_MAX  = {CNTW{1'b1}};
    localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);

    logic [CNTW-1:0] cnt_r [NREG];
    logic [NREG-1:0] inc_hit_s;
    logic [NREG-1:0] dec_hit_s;
    logic [NREG-1:0] ovf_s;
    logic [NREG-1:0] unf_s;

    for (genvar r = 0; r < NREG; r++) begin : g_cnt
        // Matching inc and dec on one register cancel; limits saturate.
        assign inc_hit_s[r] = upd_en & inc_en & (inc_addr == AW'(r)) & ~is_zero_reg(AW'(r));
        assign dec_hit_s[r] = upd_en & dec_en & (dec_addr == AW'(r)) & ~is_zero_reg(AW'(r));
        assign ovf_s[r]     = inc_hit_s[r] & ~dec_hit_s[r] & (cnt_r[r] == CNT_MAX);
        assign unf_s[r]     = dec_hit_s[r] & ~inc_hit_s[r] & (cnt_r[r] == CNT_ZERO);
        assign pend[r]      = (cnt_r[r] != CNT_ZERO);

        // Counter register for register r.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_r[r] <= CNT_ZERO;
            end else if (inc_hit_s[r] & ~dec_hit_s[r] & (cnt_r[r] != CNT_MAX)) begin
                cnt_r[r] <= cnt_r[r] + CNT_ONE;
            end else if (dec_hit_s[r] & ~inc_hit_s[r] & (cnt_r[r] != CNT_ZERO)) begin
                cnt_r[r] <= cnt_r[r] - CNT_ONE;
            end else begin
                cnt_r[r] <= cnt_r[r];
            end
        end
    end

    hazard_scoreboard_chk #(.NREG(NREG)) u_chk (
        .clk (clk),
        .rst (rst),
        .ovf (ovf_s),
        .unf (unf_s)
    );

endmodule

// File: rtl/hazard_scoreboard_chk.sv
// Simulation checker for the scoreboard: an in-flight counter must never be
// pushed past either of its limits.
module hazard_scoreboard_chk #(
    parameter int NREG = 8
) (
    input logic            clk,
    input logic            rst,
    input logic [NREG-1:0] ovf,
    input logic [NREG-1:0] unf
);

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) ovf == {NREG{1'b0}});
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) unf == {NREG{1'b0}});

endmodule

// File: rtl/hazard_sched.sv
// Pipeline sequencing controller: freeze / flush / RAW-stall / run priority,
// branch flush counter and stall performance counter around the scoreboard.
module hazard_sched
    import core_pkg::*;
#(
    parameter int NREG         = core_pkg::NREG,
    parameter int AW           = core_pkg::AW,
    parameter int CNTW         = 2,
    parameter int FLUSH_CYCLES = 1,
    parameter int PERFW        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_wr_en,
    input  logic [AW-1:0]    id_wr_addr,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    input  logic             wb_wr_en,
    input  logic [AW-1:0]    wb_write_addr,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             issue,
    output logic [PERFW-1:0] stall_count
);

    localparam logic [1:0]       FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);
    localparam logic [PERFW-1:0] PERF_MAX   = {PERFW{1'b1}};

    logic [NREG-1:0]  pend_s;
    logic             hazard_s;
    logic             branch_s;
    logic             flushing_s;
    pipe_mode_e       mode_s;
    logic [1:0]       fcnt_r;
    logic             br_latch_r;
    logic [PERFW-1:0] stall_cnt_r;

    hazard_scoreboard #(.NREG(NREG), .AW(AW), .CNTW(CNTW)) u_sb (
        .clk      (clk),
        .rst      (rst),
        .upd_en   (~rst & ~mem_busy),
        .inc_en   (issue & id_wr_en),
        .inc_addr (id_wr_addr),
        .dec_en   (wb_wr_en),
        .dec_addr (wb_write_addr),
        .pend     (pend_s)
    );

    assign hazard_s    = id_valid & ((id_uses_rs & pend_s[id_rs]) | (id_uses_rt & pend_s[id_rt]));
    // A branch seen during a freeze is replayed from br_latch_r afterwards.
    assign branch_s    = ex_branch_taken | br_latch_r;
    assign flushing_s  = branch_s | (fcnt_r != 2'd0);
    assign stall_count = stall_cnt_r;

    // Select the pipeline mode by priority.
    always_comb begin
        mode_s = MODE_RUN;
        if (mem_busy) begin
            mode_s = MODE_FREEZE;
        end else if (flushing_s) begin
            mode_s = MODE_FLUSH;
        end else if (hazard_s) begin
            mode_s = MODE_STALL;
        end else begin
            mode_s = MODE_RUN;
        end
    end

    // Decode mode into stage enables and bubble controls.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        issue       = 1'b0;
        if (rst) begin
            pc_en       = 1'b0;
        end else begin
            case (mode_s)
                MODE_FREEZE: begin
                    ifid_flush  = 1'b0;
                    idex_bubble = 1'b0;
                end
                MODE_FLUSH: begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    exmem_en = 1'b1;
                    memwb_en = 1'b1;
                end
                MODE_STALL: begin
                    ifid_flush = 1'b0;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                end
                MODE_RUN: begin
                    pc_en       = 1'b1;
                    ifid_en     = 1'b1;
                    ifid_flush  = 1'b0;
                    idex_bubble = 1'b0;
                    exmem_en    = 1'b1;
                    memwb_en    = 1'b1;
                    issue       = id_valid;
                end
                default: begin
                    pc_en = 1'b0;
                end
            endcase
        end
    end

    // Flush countdown and frozen-branch latch.
    always_ff @(posedge clk) begin
        if (rst) begin
            fcnt_r     <= 2'd0;
            br_latch_r <= 1'b0;
        end else if (mem_busy) begin
            fcnt_r     <= fcnt_r;
            br_latch_r <= br_latch_r | ex_branch_taken;
        end else if (branch_s) begin
            fcnt_r     <= FLUSH_LOAD;
            br_latch_r <= 1'b0;
        end else if (fcnt_r != 2'd0) begin
            fcnt_r     <= fcnt_r - 2'd1;
            br_latch_r <= 1'b0;
        end else begin
            fcnt_r     <= fcnt_r;
            br_latch_r <= 1'b0;
        end
    end

    // Saturating count of cycles where a valid ID instruction did not issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_r <= {PERFW{1'b0}};
        end else if (~mem_busy & id_valid & ~issue & (stall_cnt_r != PERF_MAX)) begin
            stall_cnt_r <= stall_cnt_r + PERFW'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule

// File: tb/tb_hazard_sched.sv
// Bench for hazard_sched: directed scenarios followed by random traffic, all
// checked against a per-register pending-writer model.
module tb_hazard_sched;

    localparam int FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid, id_uses_rs, id_uses_rt, id_wr_en;
    logic [2:0]  id_rs, id_rt, id_wr_addr, wb_write_addr;
    logic        ex_branch_taken, mem_busy, wb_wr_en;
    logic        pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_en, issue;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    int m_cnt [8];
    int m_fleft;
    bit m_blatch;
    int m_stall;
    bit m_known;

    logic [6:0]  o_ctrl;
    logic [15:0] o_stall;

    always #5 clk = ~clk;

    hazard_sched #(.FLUSH_CYCLES(FC)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_valid        (id_valid),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_wr_en        (id_wr_en),
        .id_wr_addr      (id_wr_addr),
        .ex_branch_taken (ex_branch_taken),
        .mem_busy        (mem_busy),
        .wb_wr_en        (wb_wr_en),
        .wb_write_addr   (wb_write_addr),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .issue           (issue),
        .stall_count     (stall_count)
    );

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_valid = 1'b0; id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_wr_en = 1'b0;
        id_rs = 3'd0; id_rt = 3'd0; id_wr_addr = 3'd0;
        ex_branch_taken = 1'b0; mem_busy = 1'b0; wb_wr_en = 1'b0; wb_write_addr = 3'd0;
        rst = 1'b0;
    endtask

    task automatic reader(input int r);
        id_valid = 1'b1; id_uses_rs = 1'b1; id_rs = 3'(r);
        id_uses_rt = 1'b0; id_wr_en = 1'b0;
    endtask

    task automatic writer(input int r);
        id_valid = 1'b1; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_wr_en = 1'b1; id_wr_addr = 3'(r);
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model.
    task automatic tick();
        bit hz, fl;
        logic [6:0] exp;
        @(negedge clk);
        hz = id_valid && ((id_uses_rs && m_cnt[id_rs] > 0) || (id_uses_rt && m_cnt[id_rt] > 0));
        fl = ex_branch_taken || m_blatch || (m_fleft > 0);
        if (rst)           exp = 7'b0011000;
        else if (mem_busy) exp = 7'b0000000;
        else if (fl)       exp = 7'b1111110;
        else if (hz)       exp = 7'b0001110;
        else               exp = {6'b110011, id_valid};
        o_ctrl  = {pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en, memwb_en, issue};
        o_stall = stall_count;
        chk(32'(o_ctrl), 32'(exp), "ctrl");
        if (m_known) chk(32'(o_stall), 32'(m_stall), "stall_count");
        @(posedge clk);
        if (rst) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_fleft = 0; m_blatch = 0; m_stall = 0; m_known = 1;
        end else if (mem_busy) begin
            if (ex_branch_taken) m_blatch = 1;
        end else begin
            if (exp[0] && id_wr_en && id_wr_addr != 3'd0) m_cnt[id_wr_addr]++;
            if (wb_wr_en && wb_write_addr != 3'd0) m_cnt[wb_write_addr]--;
            if (ex_branch_taken || m_blatch) begin
                m_fleft = FC - 1; m_blatch = 0;
            end else if (m_fleft > 0) begin
                m_fleft--;
            end
            if (id_valid && !exp[0] && m_stall < 65535) m_stall++;
        end
        #1;
    endtask

    initial begin
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_fleft = 0; m_blatch = 0; m_stall = 0; m_known = 0;
        idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;

        // RAW on R3: three stall cycles, release the cycle after WB commits
        writer(3); tick();
        reader(3); tick();
        chk(32'(o_ctrl[0]), 32'd0, "raw_issue_blocked");
        chk(32'(o_ctrl[3]), 32'd1, "raw_bubble");
        tick();
        wb_wr_en = 1'b1; wb_write_addr = 3'd3; tick();
        chk(32'(o_ctrl[0]), 32'd0, "raw_commit_cycle");
        wb_wr_en = 1'b0; tick();
        chk(32'(o_ctrl[0]), 32'd1, "raw_release");
        chk(32'(o_stall), 32'd3, "raw_stall_count");

        // Register 0 and independent registers never stall
        writer(0); tick();
        reader(0); tick();
        chk(32'(o_ctrl[0]), 32'd1, "r0_no_stall");
        writer(2); tick();
        reader(5); tick();
        chk(32'(o_ctrl[0]), 32'd1, "indep_no_stall");
        idle(); wb_wr_en = 1'b1; wb_write_addr = 3'd2; tick();
        idle();

        // Branch flush of FC cycles; concurrent hazard does not extend it
        writer(5); tick();
        reader(5); ex_branch_taken = 1'b1; tick();
        chk(32'(o_ctrl[4]), 32'd1, "flush_c0");
        ex_branch_taken = 1'b0; tick();
        chk(32'(o_ctrl[4]), 32'd1, "flush_c1");
        tick();
        chk(32'(o_ctrl[4]), 32'd0, "flush_ended");
        chk(32'(o_ctrl[6]), 32'd0, "flush_then_stall");
        wb_wr_en = 1'b1; wb_write_addr = 3'd5; tick();
        idle();

        // Freeze with a pending commit: decrement happens once, after release
        writer(4); tick();
        reader(4); mem_busy = 1'b1; wb_wr_en = 1'b1; wb_write_addr = 3'd4;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk(32'(o_ctrl), 32'd0, "freeze_all_off");
        end
        mem_busy = 1'b0; tick();
        chk(32'(o_ctrl[0]), 32'd0, "freeze_commit_cycle");
        wb_wr_en = 1'b0; tick();
        chk(32'(o_ctrl[0]), 32'd1, "freeze_release_issue");
        idle();

        // Same-cycle inc and dec on R1 leaves it pending
        writer(1); tick();
        writer(1); wb_wr_en = 1'b1; wb_write_addr = 3'd1; tick();
        wb_wr_en = 1'b0; reader(1); tick();
        chk(32'(o_ctrl[0]), 32'd0, "incdec_still_pending");
        idle(); wb_wr_en = 1'b1; wb_write_addr = 3'd1; tick();
        idle();

        // Reset mid-operation forgets writers and flush state
        writer(6); tick(); tick();
        idle(); ex_branch_taken = 1'b1; tick();
        ex_branch_taken = 1'b0; rst = 1'b1; tick();
        chk(32'(o_ctrl), 32'b0011000, "reset_outputs");
        rst = 1'b0; reader(6); tick();
        chk(32'(o_ctrl[0]), 32'd1, "post_reset_issue");
        chk(32'(o_stall), 32'd0, "post_reset_stall_count");

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            int a;
            rst             = ($urandom_range(0, 99) == 0);
            mem_busy        = ($urandom_range(0, 5) == 0);
            ex_branch_taken = ($urandom_range(0, 9) == 0);
            id_valid        = ($urandom_range(0, 3) != 0);
            id_rs           = 3'($urandom_range(0, 7));
            id_rt           = 3'($urandom_range(0, 7));
            id_uses_rs      = 1'($urandom_range(0, 1));
            id_uses_rt      = 1'($urandom_range(0, 1));
            id_wr_addr      = 3'($urandom_range(0, 7));
            id_wr_en        = ($urandom_range(0, 1) == 1) && (m_cnt[id_wr_addr] < 2);
            a               = $urandom_range(0, 7);
            wb_write_addr   = 3'(a);
            wb_wr_en        = ($urandom_range(0, 1) == 1) && (a == 0 || m_cnt[a] > 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Pipeline sequencing controller for the 16-bit 5-stage core.
- Keeps a per-register scoreboard of in-flight writes, counted from ID issue to MEM/WB commit.
- Stalls ID on read-after-write hazards and squashes IF/ID after a taken branch.
- Freezes the whole pipeline while data memory is busy, and drives the enable and bubble controls of the PC and all stage registers.

Parameters:
- NREG, 8: number of architectural registers.
- AW, 3: register address width (log2 NREG).
- CNTW, 2: per-register in-flight counter width; holds up to 3 outstanding writers.
- FLUSH_CYCLES, 1: cycles IF/ID is squashed after a taken branch, range 1..3.
- PERFW, 16: width of the stall performance counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  AW  source A address.
- id_rt  in  AW  source B address.
- id_uses_rs  in  1  instruction reads rs.
- id_uses_rt  in  1  instruction reads rt.
- id_wr_en  in  1  instruction writes the register file.
- id_wr_addr  in  AW  destination address.
- ex_branch_taken  in  1  taken branch resolved in EX this cycle.
- mem_busy  in  1  data memory not ready; whole pipeline must freeze.
- wb_wr_en  in  1  write-enable leaving MEM/WB.
- wb_write_addr  in  AW  write address leaving MEM/WB.
- pc_en  out  1  PC may advance.
- ifid_en  out  1  IF/ID may load.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_bubble  out  1  ID/EX loads a NOP.
- exmem_en  out  1  EX/MEM may load.
- memwb_en  out  1  MEM/WB may load.
- issue  out  1  ID instruction advances into ID/EX this cycle.
- stall_count  out  PERFW  saturating count of cycles with issue=0 while id_valid=1.

Behaviour:
- Reset (synchronous): all scoreboard counters=0, flush counter=0, stall_count=0. Outputs are combinational from state and inputs. During rst: pc_en=0, ifid_en=0, exmem_en=0, memwb_en=0, issue=0, ifid_flush=1, idex_bubble=1.
- Register 0 is hardwired zero: it is never counted pending and never causes a hazard.
- hazard = id_valid & ((id_uses_rs & pend[id_rs]) | (id_uses_rt & pend[id_rt])), where pend[r] = (cnt[r] != 0).
- flushing = ex_branch_taken | (fcnt != 0).
- Priority, highest first:
  1. FREEZE when mem_busy: all enables=0, ifid_flush=0, idex_bubble=0, issue=0. No scoreboard change, fcnt holds. A branch arriving while frozen is latched and taken on the first cycle mem_busy=0.
  2. FLUSH when flushing: pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1, exmem_en=memwb_en=1, issue=0. On ex_branch_taken, fcnt loads FLUSH_CYCLES-1; otherwise fcnt decrements.
  3. STALL when hazard: pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=memwb_en=1, issue=0.
  4. RUN otherwise: all enables=1, no flush or bubble, issue=id_valid.
- Scoreboard update happens only when not frozen:
  - Increment cnt[id_wr_addr] when issue & id_wr_en & id_wr_addr!=0.
  - Decrement cnt[wb_write_addr] when wb_wr_en & wb_write_addr!=0.
  - Increment and decrement on the same register in the same cycle: net unchanged.
  - Counters saturate at 0 and at 2^CNTW-1. Hitting either limit is an assertion failure in simulation.
- There is no forwarding. A write commits at the end of the WB cycle, so a dependent instruction issues the cycle after the cnt→0 update, not the same cycle.
- Squashed instructions were never counted, because issue is gated by flush. No scoreboard correction is needed.
- stall_count increments when not frozen, id_valid=1 and issue=0; it saturates at all-ones.
- Reset asserted mid-stall or mid-flush clears everything next edge; outstanding writers are forgotten. The pipeline registers are reset in the same cycle.

Decomposition:
- Shared package (core_pkg) holds AW, NREG and the NOP instruction encoding used by the stage registers.
- One natural sub-module: hazard_scoreboard (counter array, inc/dec ports, pend vector output).
- Control priority logic and the flush counter stay in hazard_sched.

Test Plan:
- RAW stall: issue write R3; next ID reads rs=3 → issue=0 and idex_bubble=1 for 3 cycles; issue=1 in the cycle after wb_wr_en with wb_write_addr=3; stall_count=3.
- Register 0 and independent regs: write R0 then read R0; write R2 then read R5 → no stall; cnt[0] stays 0.
- Branch flush, FLUSH_CYCLES=2: ex_branch_taken pulse → ifid_flush=1 and issue=0 for 2 cycles; a hazard present at the same time does not extend the flush.
- Freeze: mem_busy held 4 cycles while R4 pending and wb_wr_en=1 for R4 → all enables 0; cnt[4] unchanged until mem_busy=0, then decrements exactly once.
- Simultaneous inc/dec: issue write R1 in the same cycle WB commits R1 with cnt[1]=1 → cnt[1] stays 1; a reader of R1 still stalls.
- Reset mid-operation: cnt[6]=2, fcnt=1, assert rst one cycle → all counters 0, outputs at reset values; the first post-reset reader of R6 issues immediately.
